alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational datapath ALU.
- Keeps the base integer ops (single-cycle, registered) and adds iterative unsigned multiply and divide/remainder (one bit per cycle).
- Sits between the CPU decode/execute stage and writeback. Valid/ready on both sides lets the multi-cycle core stall on long ops.

Parameters:
- WIDTH, 32, datapath width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op present.
- in_ready  output  1  block can accept an op this cycle.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B; shifts use SrcB[SHW-1:0].
- ALUControl  input  4  operation code.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- ALUResult  output  WIDTH  registered result.
- Zero  output  1  registered (ALUResult == 0).
- Illegal  output  1  registered; the op code was unsupported.

Behaviour:
- Op encoding:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLTU (unsigned A<B -> 1, else 0); 0110 SLL; 0111 SRL; 1000 SRA (arithmetic); 1001 SLT (signed).
  - 1010 MUL (low WIDTH bits of unsigned A*B); 1011 MULHU (high WIDTH bits).
  - 1100 DIVU; 1101 REMU.
  - 1110/1111 per the optional feature.
- Illegal op: ALUResult=0, Zero=1, Illegal=1, single-cycle latency.
- All arithmetic is modulo 2^WIDTH; no carry/overflow outputs.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept = in_valid && in_ready on a rising edge.
  - Inputs are sampled only on accept; SrcA/SrcB/ALUControl may change freely afterwards.
- Single-cycle ops, illegal ops, and divide-by-zero: the result is registered on the accept edge and the state goes to DONE. out_valid is high in the next cycle (latency 1).
- MUL/MULHU/DIVU/REMU with a nonzero divisor: go to BUSY and load the iteration counter with WIDTH.
  - MUL/MULHU: shift-add, using a 2*WIDTH product register.
  - DIVU/REMU: restoring division, using a remainder/quotient register pair.
  - One iteration per cycle; the counter decrements each cycle.
  - After the final iteration, register the result and go to DONE.
  - out_valid goes high exactly WIDTH+1 cycles after the accept edge.
- Divide-by-zero (SrcB==0): DIVU -> all ones; REMU -> SrcA. Illegal=0.
- DONE:
  - out_valid=1; ALUResult/Zero/Illegal are held stable until out_ready.
  - out_ready && !in_valid -> IDLE.
  - out_ready && in_valid -> accept the new op in the same cycle. Back-to-back single-cycle ops give throughput 1/cycle.
- IDLE and BUSY: out_valid=0. ALUResult holds its last value but is don't-care while out_valid=0.
- in_valid is ignored while BUSY. in_ready=0 throughout BUSY.
- Reset (async, any state including mid-BUSY):
  - state=IDLE, counter=0, all internal registers=0.
  - out_valid=0, ALUResult=0, Zero=1, Illegal=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
  - Any op in flight is discarded; no output is produced for it.
- Shifts use only the low SHW bits of SrcB; upper bits are ignored.

Optional Feature:
- Macro: ALU_SEQ_SIGNED_DIV_EN.
- Defined:
  - 1110 DIV (signed quotient, truncating toward zero); 1111 REM (signed, sign follows dividend).
  - Implemented as the unsigned core on magnitudes plus sign fix-up in the final cycle. Latency WIDTH+1, same as DIVU.
  - Divide-by-zero: DIV -> all ones, REM -> SrcA, latency 1.
  - Overflow case (most negative value / -1): DIV -> most negative value, REM -> 0, latency 1.
- Not defined: 1110/1111 are illegal ops (ALUResult=0, Zero=1, Illegal=1, latency 1).

Test Plan:
- Reset, then ADD SrcA=0x00000005, SrcB=0xFFFFFFFB, out_ready=1 -> out_valid one cycle after accept; ALUResult=0, Zero=1, Illegal=0.
- SRA SrcA=0x80000000, SrcB=0x00000024 (shift 4), then SLT SrcA=0xFFFFFFFF, SrcB=1, back-to-back with out_ready held high -> results 0xF8000000 then 1 on consecutive cycles; in_ready never drops.
- MULHU SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> in_ready=0 for 32 cycles; out_valid at accept+33; ALUResult=0xFFFFFFFE. MUL same operands -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF at latency 1; REMU 5/0 -> 5.
- Hold out_ready=0 for 10 cycles after a DIVU completes -> ALUResult/out_valid stable, new in_valid ignored. Then pulse rst_n low mid-BUSY of a second MUL -> out_valid=0, ALUResult=0, Zero=1 immediately; no stale result after release.
- With the macro defined: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Without the macro: op 1110 -> Illegal=1, ALUResult=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. It registers the base integer ops in one cycle and runs
// unsigned MUL/MULHU/DIVU/REMU one bit per cycle. Optional macro: ALU_SEQ_SIGNED_DIV_EN (signed DIV/REM).
module alu_seq #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             Illegal,
   output logic [1:0]       dbg_state_o
);

   // Handshake: a transfer happens on a rising edge where valid && ready; the producer
   // holds valid and data until then, and the consumer may drop ready freely.

   localparam int CW = SHW + 1;
   localparam logic [3:0] OP_ADD   = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010,
                          OP_OR    = 4'b0011, OP_XOR  = 4'b0100, OP_SLTU = 4'b0101,
                          OP_SLL   = 4'b0110, OP_SRL  = 4'b0111, OP_SRA  = 4'b1000,
                          OP_SLT   = 4'b1001, OP_MUL  = 4'b1010, OP_MULHU = 4'b1011,
                          OP_DIVU  = 4'b1100, OP_REMU = 4'b1101;
`ifdef ALU_SEQ_SIGNED_DIV_EN
   localparam logic [3:0] OP_DIV   = 4'b1110, OP_REM  = 4'b1111;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             op_q, op_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]       mcand_q, mcand_d;
   logic [WIDTH-1:0]       res_q, res_d;
   logic                   zero_q, zero_d;
   logic                   ill_q, ill_d;
`ifdef ALU_SEQ_SIGNED_DIV_EN
   logic                   qneg_q, qneg_d, rneg_q, rneg_d;
   logic                   signed_op, ovf;
`endif

   logic                   accept, start_iter, q_ill, last, is_mul_in, is_mul_q, div_ge;
   logic                   a_neg, b_neg;
   logic [SHW-1:0]         shamt;
   logic [WIDTH-1:0]       q_res, dvd, dvs, mcand_init, new_rem, fin_res, quo, rem;
   logic [2*WIDTH-1:0]     acc_init, acc_step;
   logic [WIDTH:0]         mul_sum, div_shift;

   assign shamt  = SrcB[SHW-1:0];
   assign accept = in_valid && in_ready;
   assign last   = (cnt_q == CW'(1));

   // Single-cycle results and the decision whether an op needs the iterative core
   always_comb begin
      q_res      = '0;
      q_ill      = 1'b0;
      start_iter = 1'b0;
`ifdef ALU_SEQ_SIGNED_DIV_EN
      ovf        = (SrcA == MIN_NEG) && (SrcB == '1);
`endif
      case (ALUControl)
         OP_ADD:   q_res = SrcA + SrcB;
         OP_SUB:   q_res = SrcA - SrcB;
         OP_AND:   q_res = SrcA & SrcB;
         OP_OR:    q_res = SrcA | SrcB;
         OP_XOR:   q_res = SrcA ^ SrcB;
         OP_SLTU:  q_res = WIDTH'(SrcA < SrcB);
         OP_SLL:   q_res = SrcA << shamt;
         OP_SRL:   q_res = SrcA >> shamt;
         OP_SRA:   q_res = $signed(SrcA) >>> shamt;
         OP_SLT:   q_res = WIDTH'($signed(SrcA) < $signed(SrcB));
         OP_MUL, OP_MULHU: start_iter = 1'b1;
         OP_DIVU:  if (SrcB == '0) q_res = '1;   else start_iter = 1'b1;
         OP_REMU:  if (SrcB == '0) q_res = SrcA; else start_iter = 1'b1;
`ifdef ALU_SEQ_SIGNED_DIV_EN
         OP_DIV: begin
            if (SrcB == '0)  q_res = '1;
            else if (ovf)    q_res = MIN_NEG;
            else             start_iter = 1'b1;
         end
         OP_REM: begin
            if (SrcB == '0)  q_res = SrcA;
            else if (ovf)    q_res = '0;
            else             start_iter = 1'b1;
         end
`endif
         default:  q_ill = 1'b1;
      endcase
   end

   // Operand preparation: signed divides run on magnitudes
   always_comb begin
`ifdef ALU_SEQ_SIGNED_DIV_EN
      signed_op = (ALUControl[3:1] == 3'b111);
      a_neg     = signed_op && SrcA[WIDTH-1];
      b_neg     = signed_op && SrcB[WIDTH-1];
`else
      a_neg     = 1'b0;
      b_neg     = 1'b0;
`endif
      dvd        = a_neg ? (-SrcA) : SrcA;
      dvs        = b_neg ? (-SrcB) : SrcB;
      is_mul_in  = (ALUControl[3:1] == 3'b101);
      acc_init   = is_mul_in ? {{WIDTH{1'b0}}, SrcB} : {{WIDTH{1'b0}}, dvd};
      mcand_init = is_mul_in ? SrcA : dvs;
   end

   // One shift-add or restoring-divide step per cycle on {high, low}
   always_comb begin
      is_mul_q  = (op_q[3:1] == 3'b101);
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{acc_q[0]}}};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, mcand_q});
      new_rem   = div_ge ? (div_shift[WIDTH-1:0] - mcand_q) : div_shift[WIDTH-1:0];
      acc_step  = is_mul_q ? {mul_sum, acc_q[WIDTH-1:1]}
                           : {new_rem, acc_q[WIDTH-2:0], div_ge};
      quo       = acc_step[WIDTH-1:0];
      rem       = acc_step[2*WIDTH-1:WIDTH];
      case (op_q)
         OP_MULHU: fin_res = rem;
         OP_REMU:  fin_res = rem;
`ifdef ALU_SEQ_SIGNED_DIV_EN
         OP_DIV:   fin_res = qneg_q ? (-quo) : quo;
         OP_REM:   fin_res = rneg_q ? (-rem) : rem;
`endif
         default:  fin_res = quo;
      endcase
   end

   // Datapath next state
   always_comb begin
      op_d    = op_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ill_d   = ill_q;
`ifdef ALU_SEQ_SIGNED_DIV_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      if (accept) begin
         op_d = ALUControl;
         if (start_iter) begin
            cnt_d   = CW'(WIDTH);
            acc_d   = acc_init;
            mcand_d = mcand_init;
`ifdef ALU_SEQ_SIGNED_DIV_EN
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
`endif
         end else begin
            res_d  = q_res;
            zero_d = (q_res == '0);
            ill_d  = q_ill;
         end
      end else if (state_q == S_BUSY) begin
         acc_d = acc_step;
         cnt_d = cnt_q - CW'(1);
         if (last) begin
            res_d  = fin_res;
            zero_d = (fin_res == '0);
            ill_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         res_q   <= '0;
         zero_q  <= 1'b1;
         ill_q   <= 1'b0;
`ifdef ALU_SEQ_SIGNED_DIV_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ill_q   <= ill_d;
`ifdef ALU_SEQ_SIGNED_DIV_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = start_iter ? S_BUSY : S_DONE;
         S_BUSY: if (last)   state_d = S_DONE;
         S_DONE: begin
            if (accept)         state_d = start_iter ? S_BUSY : S_DONE;
            else if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
      out_valid   = (state_q == S_DONE);
      ALUResult   = res_q;
      Zero        = zero_q;
      Illegal     = ill_q;
      dbg_state_o = state_q;
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed steps plus random ops checked against a plain-arithmetic model.
// Define ALU_SEQ_SIGNED_DIV_EN for both bench and RTL to cover signed DIV/REM.
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, Zero, Illegal;
  logic [W-1:0] SrcA, SrcB, ALUResult;
  logic [3:0]   ALUControl;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero), .Illegal(Illegal),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: result, illegal flag and latency from the op definitions
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ill, output int lat);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    r = '0;
    ill = 1'b0;
    lat = 1;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (a < b) ? 1 : 0;
      4'd6:  r = a << b[4:0];
      4'd7:  r = a >> b[4:0];
      4'd8:  r = $signed(a) >>> b[4:0];
      4'd9:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd10: begin r = p[31:0];  lat = W + 1; end
      4'd11: begin r = p[63:32]; lat = W + 1; end
      4'd12: if (b == 0) r = '1; else begin r = a / b; lat = W + 1; end
      4'd13: if (b == 0) r = a;  else begin r = a % b; lat = W + 1; end
`ifdef ALU_SEQ_SIGNED_DIV_EN
      4'd14: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin r = $signed(a) / $signed(b); lat = W + 1; end
      end
      4'd15: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else begin r = $signed(a) % $signed(b); lat = W + 1; end
      end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // Issue one op with out_ready high, then check latency, busy window and result
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [W-1:0] exp_r;
    logic exp_ill;
    int exp_lat, cyc, busy_low;
    model(op, a, b, exp_r, exp_ill, exp_lat);
    @(negedge clk);
    ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom_range(0, 15));
    cyc = 1;
    busy_low = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && cyc < 3 * W) begin
      if (in_ready === 1'b0) busy_low++;
      @(negedge clk);
      cyc++;
    end
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " busy_cycles"}, busy_low, exp_lat - 1);
    check({tag, " result"}, ALUResult, exp_r);
    check({tag, " zero"}, Zero, (exp_r == 0) ? 1 : 0);
    check({tag, " illegal"}, Illegal, exp_ill);
  endtask

  initial begin
    logic [W-1:0] held;
    int seen_valid;
    in_valid = 1'b0; out_ready = 1'b0; SrcA = '0; SrcB = '0; ALUControl = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst result", ALUResult, 0);
    check("rst zero", Zero, 1);
    check("rst illegal", Illegal, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst in_ready", in_ready, 1);

    // Directed ops
    run_op("add_zero", 4'd0, 32'h0000_0005, 32'hFFFF_FFFB);
    run_op("mulhu_max", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_max", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu_100_7", 4'd12, 32'd100, 32'd7);
    run_op("remu_100_7", 4'd13, 32'd100, 32'd7);
    run_op("divu_by0", 4'd12, 32'd5, 32'd0);
    run_op("remu_by0", 4'd13, 32'd5, 32'd0);
    run_op("op1110", 4'd14, 32'h1234_5678, 32'd3);
    run_op("sll_upper", 4'd6, 32'h0000_0003, 32'hFFFF_FFE4);
`ifdef ALU_SEQ_SIGNED_DIV_EN
    run_op("div_m7_2", 4'd14, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", 4'd15, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 4'd15, 32'h8000_0000, 32'hFFFF_FFFF);
`endif

    // Back-to-back single-cycle ops with out_ready held high
    @(negedge clk);
    ALUControl = 4'd8; SrcA = 32'h8000_0000; SrcB = 32'h0000_0024; in_valid = 1'b1; out_ready = 1'b1;
    check("b2b in_ready0", in_ready, 1);
    @(negedge clk);
    check("b2b sra valid", out_valid, 1);
    check("b2b sra result", ALUResult, 32'hF800_0000);
    ALUControl = 4'd9; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
    check("b2b in_ready1", in_ready, 1);
    @(negedge clk);
    check("b2b slt valid", out_valid, 1);
    check("b2b slt result", ALUResult, 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b drained", out_valid, 0);

    // Output stall: result held, new requests ignored
    @(negedge clk);
    ALUControl = 4'd12; SrcA = 32'd1000; SrcB = 32'd9; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3 * W && out_valid !== 1'b1; i++) @(negedge clk);
    check("stall valid", out_valid, 1);
    check("stall result", ALUResult, 32'd111);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; ALUControl = 4'd0; SrcA = $urandom; SrcB = $urandom;
      @(negedge clk);
      check("stall hold valid", out_valid, 1);
      check("stall hold result", ALUResult, 32'd111);
      check("stall in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("stall release", out_valid, 0);

    // Reset in the middle of a multiply
    ALUControl = 4'd10; SrcA = 32'h0001_2345; SrcB = 32'h0000_6789; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midbusy in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst result", ALUResult, 0);
    check("midrst zero", Zero, 1);
    check("midrst illegal", Illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_valid++;
    end
    check("midrst no_stale", seen_valid, 0);
    check("midrst in_ready", in_ready, 1);

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 40);
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    held = ALUResult;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
